// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: instruction encodings,
// FSM states and access-width decoding.
package mem_stage_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    GET_INSTR,
    MEM_REQ,
    MEM_WAIT,
    GIVE_WB
  } mem_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } mem_size_e;

  // Unknown funct3 encodings fall back to a full-word access.
  function automatic mem_size_e load_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: load_size = SIZE_BYTE;
      F3_H, F3_HU: load_size = SIZE_HALF;
      default:     load_size = SIZE_WORD;
    endcase
  endfunction

  function automatic mem_size_e store_size(input logic [2:0] funct3);
    case (funct3)
      F3_B:    store_size = SIZE_BYTE;
      F3_H:    store_size = SIZE_HALF;
      default: store_size = SIZE_WORD;
    endcase
  endfunction

  function automatic logic load_signed(input logic [2:0] funct3);
    load_signed = (funct3 == F3_B) || (funct3 == F3_H);
  endfunction

endpackage

// File: rtl/mem_lsu_format.sv
// Combinational lane handling: store byte-enables/replicated write data and
// load byte/half extraction with sign or zero extension.
module mem_lsu_format
  import mem_stage_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  mem_size_e   size;
  logic        sext;
  logic [31:0] rdata_shifted;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    size          = is_store_i ? store_size(funct3_i) : load_size(funct3_i);
    sext          = load_signed(funct3_i);
    rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
    load_byte     = rdata_shifted[7:0];
    load_half     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o          = 4'b1111;
    wdata_o       = rs2_i;
    load_data_o   = rdata_i;

    case (size)
      SIZE_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{rs2_i[7:0]}};
        load_data_o = {{24{sext & load_byte[7]}}, load_byte};
      end
      SIZE_HALF: begin
        be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o     = {2{rs2_i[15:0]}};
        load_data_o = {{16{sext & load_half[15]}}, load_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: takes one instruction from execute, performs
// at most one load/store on the req/gnt/rvalid bus, then hands off to write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic               EX_MEM_give_i,
  output logic               MEM_EX_get_o,
  input  logic [31:0]        EX_MEM_instruction_i,
  input  logic [BITSIZE-1:0] EX_MEM_result_i,
  input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
  input  logic               WB_MEM_get_i,
  output logic               MEM_WB_give_o,
  output logic [31:0]        MEM_WB_instruction_o,
  output logic [BITSIZE-1:0] MEM_WB_result_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [3:0]         mem_be_o,
  output logic [31:0]        mem_wdata_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [31:0]        mem_rdata_i
);

  mem_state_e         state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [BITSIZE-1:0] result_q, result_d;
  logic [BITSIZE-1:0] rs2_q, rs2_d;
  logic               alive_q;

  logic [6:0]  ex_opcode;
  logic        ex_xfer;
  logic        is_store_q;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_load_data;

  assign ex_opcode  = EX_MEM_instruction_i[6:0];
  assign is_store_q = (instr_q[6:0] == OPC_STORE);
  // get stays low while reset is held and until the first edge after release.
  assign ex_xfer    = EX_MEM_give_i && alive_q && (state_q == GET_INSTR);

  mem_lsu_format u_lsu (
    .is_store_i  (is_store_q),
    .funct3_i    (instr_q[14:12]),
    .addr_lo_i   (result_q[1:0]),
    .rs2_i       (rs2_q),
    .rdata_i     (mem_rdata_i),
    .be_o        (lsu_be),
    .wdata_o     (lsu_wdata),
    .load_data_o (lsu_load_data)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    rs2_d    = rs2_q;

    MEM_EX_get_o         = 1'b0;
    MEM_WB_give_o        = 1'b0;
    MEM_WB_instruction_o = instr_q;
    MEM_WB_result_o      = result_q;
    mem_req_o            = 1'b0;
    mem_we_o             = 1'b0;
    mem_addr_o           = '0;
    mem_be_o             = '0;
    mem_wdata_o          = '0;

    case (state_q)
      GET_INSTR: begin
        MEM_EX_get_o = alive_q;
        if (ex_xfer) begin
          instr_d  = EX_MEM_instruction_i;
          result_d = EX_MEM_result_i;
          rs2_d    = EX_MEM_rs2_i;
          state_d  = ((ex_opcode == OPC_LOAD) || (ex_opcode == OPC_STORE)) ? MEM_REQ : GIVE_WB;
        end
      end
      MEM_REQ: begin
        // Bus fields come straight from registers, so they cannot move before gnt.
        mem_req_o   = 1'b1;
        mem_we_o    = is_store_q;
        mem_addr_o  = {result_q[31:2], 2'b00};
        mem_be_o    = lsu_be;
        mem_wdata_o = lsu_wdata;
        if (mem_gnt_i) begin
          state_d = is_store_q ? GIVE_WB : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_rvalid_i) begin
          result_d = lsu_load_data;
          state_d  = GIVE_WB;
        end
      end
      GIVE_WB: begin
        MEM_WB_give_o = 1'b1;
        if (WB_MEM_get_i) begin
          state_d = GET_INSTR;
        end
      end
      default: state_d = GET_INSTR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= GET_INSTR;
      instr_q  <= '0;
      result_q <= '0;
      rs2_q    <= '0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      rs2_q    <= rs2_d;
      alive_q  <= 1'b1;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between execute and write-back. Accepts an instruction, ALU result and rs2 value from execute over the give/get handshake, performs at most one data-memory transaction (load or store) over a req/gnt/rvalid bus, formats load data, and hands instruction plus final result to write-back. Non-memory instructions pass through without touching the bus.

## Interface
- BITSIZE, 32, datapath width; the memory bus is fixed at 32 bits and only BITSIZE = 32 is supported.
- clk  in  1  clock, all state on rising edge
- resetn_i  in  1  asynchronous active-low reset
- EX_MEM_give_i  in  1  execute holds a valid instruction
- MEM_EX_get_o  out  1  mem_stage can accept an instruction
- EX_MEM_instruction_i  in  32  instruction word
- EX_MEM_result_i  in  BITSIZE  ALU result (effective address for load/store)
- EX_MEM_rs2_i  in  BITSIZE  store data
- WB_MEM_get_i  in  1  write-back can accept
- MEM_WB_give_o  out  1  mem_stage holds a valid result
- MEM_WB_instruction_o  out  32  instruction word passed on
- MEM_WB_result_o  out  BITSIZE  load data, or ALU result for all other opcodes
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-shifted store data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data

## Operation
- Handshake: transfer happens in a cycle where give and get are both 1; data is captured into internal registers on that edge.
- FSM states: GET_INSTR, MEM_REQ, MEM_WAIT, GIVE_WB.
- GET_INSTR: MEM_EX_get_o = 1. On transfer: LOAD (opcode 0000011) or STORE (0100011) -> MEM_REQ; anything else -> GIVE_WB, with the result equal to the captured ALU result.
- MEM_REQ: mem_req_o = 1; addr/be/we/wdata held stable until mem_gnt_i. On gnt: store -> GIVE_WB (result = address); load -> MEM_WAIT.
- MEM_WAIT: on mem_rvalid_i, the formatted load data is registered -> GIVE_WB. rvalid may arrive in the cycle after gnt or later.
- GIVE_WB: MEM_WB_give_o = 1; outputs held stable until WB_MEM_get_i; then -> GET_INSTR.
- Lane selection from addr[1:0]:
  - Byte: be = 1<<addr[1:0].
  - Half: be = 0011 or 1100, selected by addr[1]; addr[0] is ignored.
  - Word: be = 1111; addr[1:0] are ignored.
  - wdata is rs2 replicated across lanes (byte x4, half x2).
- funct3 mapping:
  - Load: 000 LB and 001 LH sign-extend; 010 LW; 100 LBU and 101 LHU zero-extend.
  - Store: 000 SB, 001 SH, 010 SW.
  - Any other load funct3 is treated as LW; any other store funct3 as SW.
- Reset value of every output is 0 (including mem_be_o and all data outputs). FSM resets to GET_INSTR. Deassertion of resetn_i mid-transaction abandons the transaction; no bus output stays asserted.

## Timing
- Non-memory instruction: accepted at edge N; MEM_WB_give_o = 1 from cycle N+1.
- Store: req from N+1; with gnt in N+1, give from N+2.
- Load: req at N+1, gnt at N+1, rvalid at N+2 -> give from N+3.
- MEM_EX_get_o is 0 in all states except GET_INSTR; there is no overlap, so throughput is at most one instruction per 2 cycles.
- Back-pressure: WB_MEM_get_i = 0 holds GIVE_WB indefinitely with all outputs constant.
- mem_req_o never drops before gnt. No new request is issued while in MEM_WAIT.

## Structure
- Opcode constants (LOAD, STORE) and funct3 encodings come from the shared instruction definitions. The FSM state enum and width-select constants go in a shared core package.
- One sub-module: mem_lsu_format, purely combinational. It does store lane shift/byte-enable generation and load extraction with sign/zero extension.

## Test plan
- ADD result 0x0000_1234 given, WB get = 1 -> MEM_WB_result_o = 0x0000_1234 one cycle after transfer, no mem_req_o.
- SB addr 0x1003, rs2 0xAABBCCDD -> be = 1000, wdata = 0xDDDDDDDD, addr = 0x1000, we = 1.
- LB addr 0x2001, rdata 0x0000_8000 -> result 0xFFFF_FF80; LBU on the same data -> 0x0000_0080.
- LW with gnt delayed 3 cycles and rvalid 2 cycles later -> req and address stable throughout; result equals rdata; get stays 0 until after WB accepts.
- SH addr 0x3002, rs2 0x0000_BEEF, WB get held 0 for 4 cycles -> be = 1100, wdata = 0xBEEFBEEF; give and outputs stable for those 4 cycles.
- resetn_i pulsed low in MEM_WAIT -> all outputs 0 immediately; after release get = 1, and a late rvalid is ignored.
